// File: rtl/fe_hit_concentrator.sv
// fe_hit_concentrator
//   Captures the hit slots of up to four FE chips on each BX strobe into a
//   NEXT/ACTIVE double buffer. Each BX is emitted as one framed stream:
//   header, then one word per valid hit in slot order, then a trailer.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   en            capture enable (bx_strobe ignored while low)
//   bx_strobe     one-cycle BX marker, hit inputs sampled only here
//   hit_dv        S slot-valid bits, slot s = fe*3 + h
//   hit_data      S x 13-bit words {stub[7:0], bend[4:0]}
//   out_valid     output word valid (registered)
//   out_data      20-bit framed word (registered)
//   out_ready     downstream accept
//   busy          FSM not idle or NEXT buffer occupied
//   drop_cnt      saturating count of BXs dropped on overflow
module fe_hit_concentrator #(
    parameter int N_FE = 4,
    localparam int S = 3 * N_FE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            bx_strobe,
    input  logic [S-1:0]    hit_dv,
    input  logic [13*S-1:0] hit_data,
    output logic            out_valid,
    output logic [19:0]     out_data,
    input  logic            out_ready,
    output logic            busy,
    output logic [15:0]     drop_cnt
);

    typedef enum logic [1:0] {IDLE, HEADER, HITS, TRAILER} state_t;

    state_t state, state_n;

    // NEXT buffer
    logic              nxt_full;
    logic [S-1:0]      nxt_mask;
    logic [S-1:0][12:0] nxt_data;
    logic [15:0]       nxt_bx;

    // ACTIVE buffer, read by the FSM
    logic [S-1:0]      act_mask, act_mask_n;
    logic [S-1:0][12:0] act_data, act_data_n;
    logic [15:0]       act_bx, act_bx_n;
    logic              act_ovf, act_ovf_n;
    logic [3:0]        hit_cnt, hit_cnt_n;

    logic [15:0]       bx_id;
    logic              ovf;

    logic              xfer, load, capture, accept, drop;
    logic [S-1:0]      lowbit;
    logic [1:0]        sel_fe, sel_h;
    logic [12:0]       sel_data;
    logic              valid_n;
    logic [19:0]       word_n;

    assign xfer    = out_valid & out_ready;
    assign load    = (state == IDLE) & nxt_full;
    assign capture = bx_strobe & en;
    // NEXT can take a new BX if empty or being emptied into ACTIVE this edge
    assign accept  = capture & (~nxt_full | load);
    assign drop    = capture & ~accept;
    assign busy    = (state != IDLE) | nxt_full;

    // isolate the lowest set bit of the mask (two's-complement trick)
    assign lowbit  = act_mask & (~act_mask + {{(S-1){1'b0}}, 1'b1});

    // ACTIVE buffer next values; the output word is built from these so the
    // registered output lines up with the state it belongs to
    always_comb begin
        act_mask_n = act_mask;
        act_data_n = act_data;
        act_bx_n   = act_bx;
        act_ovf_n  = act_ovf;
        hit_cnt_n  = hit_cnt;
        if (load) begin
            act_mask_n = nxt_mask;
            act_data_n = nxt_data;
            act_bx_n   = nxt_bx;
            // the sticky flag is handed to the frame being opened, so a drop
            // is reported by the frame that follows it
            act_ovf_n  = ovf;
            hit_cnt_n  = 4'd0;
        end else if (state == HITS && xfer) begin
            act_mask_n = act_mask & ~lowbit;
            hit_cnt_n  = hit_cnt + 4'd1;
        end
    end

    // state register, buffers, counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            nxt_full  <= 1'b0;
            nxt_mask  <= '0;
            nxt_data  <= '0;
            nxt_bx    <= '0;
            act_mask  <= '0;
            act_data  <= '0;
            act_bx    <= '0;
            act_ovf   <= 1'b0;
            hit_cnt   <= '0;
            bx_id     <= '0;
            ovf       <= 1'b0;
            drop_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            act_mask  <= act_mask_n;
            act_data  <= act_data_n;
            act_bx    <= act_bx_n;
            act_ovf   <= act_ovf_n;
            hit_cnt   <= hit_cnt_n;
            out_valid <= valid_n;
            out_data  <= word_n;

            if (accept) begin
                nxt_full <= 1'b1;
                nxt_mask <= hit_dv;
                nxt_bx   <= bx_id;
                for (int s = 0; s < S; s++)
                    nxt_data[s] <= hit_data[13*s +: 13];
            end else if (load) begin
                nxt_full <= 1'b0;
            end

            // dropped BXs consume an id as well
            if (capture)
                bx_id <= bx_id + 16'd1;
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            ovf <= drop | (ovf & ~load);
        end
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (nxt_full) state_n = HEADER;
            HEADER:  if (xfer) state_n = (act_mask != '0) ? HITS : TRAILER;
            HITS:    if (xfer && act_mask_n == '0) state_n = TRAILER;
            TRAILER: if (xfer) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // output word for the upcoming state; lowest-index slot wins
    always_comb begin
        sel_fe   = 2'd0;
        sel_h    = 2'd0;
        sel_data = act_data_n[0];
        for (int i = S - 1; i >= 0; i--) begin
            if (act_mask_n[i]) begin
                sel_fe   = 2'(i / 3);
                sel_h    = 2'(i % 3);
                sel_data = act_data_n[i];
            end
        end
        valid_n = (state_n != IDLE);
        word_n  = '0;
        case (state_n)
            HEADER:  word_n = {2'b01, 2'b00, act_bx_n};
            HITS:    word_n = {2'b10, sel_fe, sel_h, 1'b0, sel_data};
            TRAILER: word_n = {2'b11, act_ovf_n, 1'b0, act_bx_n[11:0], hit_cnt_n};
            default: word_n = '0;
        endcase
    end

endmodule
